// File: rtl/alu_multishift_sequencer.sv
// Multi-cycle shift/rotate sequencer: expands one N-bit request into N single-bit
// steps on the shared ALU, feeding ALUOut back into the work register each cycle.
module alu_multishift_sequencer #(
   parameter int         DATA_WIDTH  = 32,
   parameter int         CNT_WIDTH   = 5,
   parameter logic [4:0] IDLE_FUNSEL = 5'b10000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [DATA_WIDTH-1:0] i_operand,
   input  logic [CNT_WIDTH-1:0]  i_shift_amt,
   input  logic [2:0]            i_shift_type,
   input  logic                  i_width32,
   input  logic [DATA_WIDTH-1:0] i_alu_out,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [4:0]            o_alu_funsel,
   output logic                  o_alu_wf,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [DATA_WIDTH-1:0] o_result
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_work, r_result;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [3:0]            r_code;
   logic                  r_w32, r_error;
   logic                  w_valid, w_accept, w_last;
   logic [3:0]            w_code;

   // Shift types 000..100 map onto consecutive ALU codes 1011..1111.
   assign w_valid  = (i_shift_type <= 3'd4);
   assign w_code   = 4'd11 + {1'b0, i_shift_type};
   assign w_accept = (r_state == S_IDLE) && i_start && w_valid;
   assign w_last   = (r_cnt == CNT_WIDTH'(1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = (i_shift_amt == '0) ? S_DONE : S_SHIFT;
         S_SHIFT: if (i_abort) w_next = S_IDLE;
                  else if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_work   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_code   <= '0;
         r_w32    <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_error <= (r_state == S_IDLE) && i_start && !w_valid;
         // Result is captured on entry to DONE so it is already valid alongside Done.
         if (w_accept) begin
            r_work <= i_operand;
            r_cnt  <= i_shift_amt;
            r_code <= w_code;
            r_w32  <= i_width32;
            if (i_shift_amt == '0) r_result <= i_operand;
         end else if (r_state == S_SHIFT && !i_abort) begin
            r_work <= i_alu_out;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) r_result <= i_alu_out;
         end
      end
   end

   assign o_alu_a      = r_work;
   assign o_busy       = (r_state == S_SHIFT);
   assign o_done       = (r_state == S_DONE);
   assign o_alu_wf     = (r_state == S_SHIFT);
   assign o_alu_funsel = (r_state == S_SHIFT) ? {r_w32, r_code} : IDLE_FUNSEL;
   assign o_error      = r_error;
   assign o_result     = r_result;

endmodule
